// File: rtl/seg_scan_pkg.sv
// Shared constants and types for the HH:MM seven-segment scan controller.
// Optional brightness control is enabled with the SEG_SCAN_DIM_EN macro.
package seg_scan_pkg;

    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned DIGIT_W    = 4;
    localparam logic [3:0]  AN_OFF     = 4'b1111;

    typedef logic [1:0] digit_idx_t;

    localparam digit_idx_t IDX_HTENS = 2'd3;
    localparam digit_idx_t IDX_COLON = 2'd2;
    localparam digit_idx_t IDX_PM    = 2'd0;

    typedef enum logic {
        ST_BLANK,
        ST_DRIVE
    } scan_phase_t;

endpackage

// File: rtl/seg_slot_timer.sv
// Slot timer: counts cycles within a slot, steps the digit index and flags frame start.
// With SEG_SCAN_DIM_EN defined the raw slot count is exported for on-time gating.
module seg_slot_timer
    import seg_scan_pkg::*;
#(
    parameter int unsigned CLK_DIV      = 50000,
    parameter int unsigned BLANK_CYCLES = 16,
    localparam int unsigned CntW        = $clog2(CLK_DIV)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    output scan_phase_t     phase_o,
    output digit_idx_t      idx_o,
    output logic            frame_start_o
`ifdef SEG_SCAN_DIM_EN
    ,
    output logic [CntW-1:0] cnt_o
`endif
);

    logic [CntW-1:0] cnt_q, cnt_d;
    digit_idx_t      idx_q, idx_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
        end
    end

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        idx_d = idx_q;
        if (cnt_q == CntW'(CLK_DIV - 1)) begin
            cnt_d = '0;
            idx_d = idx_q + 2'd1;
        end
    end

    always_comb begin
        phase_o = (32'(cnt_q) < BLANK_CYCLES) ? ST_BLANK : ST_DRIVE;
        idx_o   = idx_q;
        // Gated by reset so no capture pulse is reported while held in reset.
        frame_start_o = !rst_i && (cnt_q == '0) && (idx_q == '0);
    end

`ifdef SEG_SCAN_DIM_EN
    assign cnt_o = cnt_q;
`endif

endmodule

// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed display driver: per-frame snapshot, anti-ghost blanking,
// leading-zero/invalid-digit suppression and colon/PM dots. Macro SEG_SCAN_DIM_EN adds dimming.
module seg_scan_ctrl
    import seg_scan_pkg::*;
#(
    parameter int unsigned CLK_DIV      = 50000,
    parameter int unsigned BLANK_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] digits_in,
    input  logic        pm,
    input  logic        colon_on,
`ifdef SEG_SCAN_DIM_EN
    input  logic [1:0]  dim,
`endif
    output logic [3:0]  dec_in,
    output logic [3:0]  an_n,
    output logic        dp_n,
    output logic [1:0]  digit_sel,
    output logic        frame_start
);

    localparam int unsigned CntW = $clog2(CLK_DIV);

    scan_phase_t phase;
    digit_idx_t  idx;
    logic        fs;

    logic [15:0] snap_q, snap_d;
    logic        snap_pm_q, snap_pm_d;
    logic        snap_colon_q, snap_colon_d;

    logic [DIGIT_W-1:0] digit;
    logic               digit_blank;
    logic               dim_on;
    logic               lit;

`ifdef SEG_SCAN_DIM_EN
    logic [CntW-1:0] cnt;
    logic [1:0]      snap_dim_q, snap_dim_d;
    logic [31:0]     on_elapsed, on_limit;
`endif

    seg_slot_timer #(
        .CLK_DIV      (CLK_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_timer (
        .clk_i         (clk),
        .rst_i         (reset),
        .phase_o       (phase),
        .idx_o         (idx),
        .frame_start_o (fs)
`ifdef SEG_SCAN_DIM_EN
        ,
        .cnt_o         (cnt)
`endif
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            snap_q       <= '0;
            snap_pm_q    <= 1'b0;
            snap_colon_q <= 1'b0;
        end else begin
            snap_q       <= snap_d;
            snap_pm_q    <= snap_pm_d;
            snap_colon_q <= snap_colon_d;
        end
    end

    always_comb begin
        snap_d       = snap_q;
        snap_pm_d    = snap_pm_q;
        snap_colon_d = snap_colon_q;
        if (fs) begin
            snap_d       = digits_in;
            snap_pm_d    = pm;
            snap_colon_d = colon_on;
        end
    end

`ifdef SEG_SCAN_DIM_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            snap_dim_q <= '0;
        end else begin
            snap_dim_q <= snap_dim_d;
        end
    end

    always_comb begin
        snap_dim_d = snap_dim_q;
        if (fs) begin
            snap_dim_d = dim;
        end
    end

    // Only meaningful in ST_DRIVE; the subtraction wraps during blanking but is masked.
    assign on_elapsed = (32'(cnt) - BLANK_CYCLES) << 2;
    assign on_limit   = (32'(snap_dim_q) + 32'd1) * (CLK_DIV - BLANK_CYCLES);
    assign dim_on     = on_elapsed < on_limit;
`else
    assign dim_on = 1'b1;
`endif

    always_comb begin
        digit       = snap_q[{idx, 2'b00} +: DIGIT_W];
        digit_blank = (digit > 4'd9) || ((idx == IDX_HTENS) && (digit == 4'd0));
        lit         = (phase == ST_DRIVE) && dim_on && !digit_blank;

        dec_in      = digit;
        digit_sel   = idx;
        frame_start = fs;

        an_n = AN_OFF;
        dp_n = 1'b1;
        if (lit) begin
            an_n[idx] = 1'b0;
            if (((idx == IDX_COLON) && snap_colon_q) || ((idx == IDX_PM) && snap_pm_q)) begin
                dp_n = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Randomized bench for seg_scan_ctrl against a frame-position reference model.
// Works with or without SEG_SCAN_DIM_EN defined.
module tb_seg_scan_ctrl;

    localparam int unsigned CLK_DIV = 8;
    localparam int unsigned BLANK   = 2;
    localparam int          FRAME   = 4 * CLK_DIV;

    logic        clk;
    logic        reset;
    logic [15:0] digits_in;
    logic        pm;
    logic        colon_on;
    logic [1:0]  dim;
    logic [3:0]  dec_in;
    logic [3:0]  an_n;
    logic        dp_n;
    logic [1:0]  digit_sel;
    logic        frame_start;

    int n_checks = 0;
    int n_pass   = 0;

    seg_scan_ctrl #(
        .CLK_DIV      (CLK_DIV),
        .BLANK_CYCLES (BLANK)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .digits_in   (digits_in),
        .pm          (pm),
        .colon_on    (colon_on),
`ifdef SEG_SCAN_DIM_EN
        .dim         (dim),
`endif
        .dec_in      (dec_in),
        .an_n        (an_n),
        .dp_n        (dp_n),
        .digit_sel   (digit_sel),
        .frame_start (frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: position within the scan since reset release plus the per-frame snapshot.
    int          pos;
    logic [15:0] m_snap;
    logic        m_pm, m_colon;
    logic [1:0]  m_dim;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            pos     <= 0;
            m_snap  <= '0;
            m_pm    <= 1'b0;
            m_colon <= 1'b0;
            m_dim   <= 2'd0;
        end else begin
            if (pos % FRAME == 0) begin
                m_snap  <= digits_in;
                m_pm    <= pm;
                m_colon <= colon_on;
                m_dim   <= dim;
            end
            pos <= pos + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (pos %0d, t=%0t)", tag, got, exp, pos, $time);
        end
    endtask

    task automatic check_all();
        logic [3:0] e_an, e_dec;
        logic       e_dp, e_fs;
        logic [1:0] e_sel;
        int         c, ix, d;
        bit         on;
        if (reset) begin
            e_an = 4'hF; e_dec = 4'h0; e_dp = 1'b1; e_sel = 2'd0; e_fs = 1'b0;
        end else begin
            c     = pos % CLK_DIV;
            ix    = (pos / CLK_DIV) % 4;
            d     = (m_snap >> (4 * ix)) & 15;
            e_dec = 4'(d);
            e_sel = 2'(ix);
            e_fs  = (pos % FRAME == 0);
            on    = (c >= BLANK) && (d <= 9) && !(ix == 3 && d == 0);
`ifdef SEG_SCAN_DIM_EN
            if (4 * (c - int'(BLANK)) >= (int'(m_dim) + 1) * int'(CLK_DIV - BLANK)) on = 0;
`endif
            e_an = on ? ~(4'b0001 << ix) : 4'hF;
            e_dp = !(on && ((ix == 2 && m_colon) || (ix == 0 && m_pm)));
        end
        check("an_n", an_n, e_an);
        check("dp_n", dp_n, e_dp);
        check("dec_in", dec_in, e_dec);
        check("digit_sel", digit_sel, e_sel);
        check("frame_start", frame_start, e_fs);
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check_all();
        end
    endtask

    // Advance to the given position within the frame (bounded).
    task automatic align(input int frame_pos);
        int k;
        k = 0;
        while ((pos % FRAME) != frame_pos && k < 2 * FRAME) begin
            step(1);
            k++;
        end
        check("align_bound", (k < 2 * FRAME), 1);
    endtask

    initial begin
        reset     = 1'b1;
        digits_in = 16'h1245;
        pm        = 1'b1;
        colon_on  = 1'b1;
        dim       = 2'd3;
        step(3);

        // Scenario 1: release reset; frame_start must be high immediately.
        reset = 1'b0;
        #1;
        check("fs_after_release", frame_start, 1);
        check_all();
        step(2 * FRAME);

        // Scenario 2: leading hour zero is blanked.
        digits_in = 16'h0930;
        align(0);
        step(FRAME);

        // Scenario 3: mid-frame change is invisible until the next frame.
        digits_in = 16'h1159;
        align(0);
        step(10);
        digits_in = 16'h1200;
        step(2 * FRAME);

        // Scenario 4: invalid nibble in slot 1.
        digits_in = 16'h12A5;
        align(0);
        step(FRAME);

        // Scenario 5: asynchronous reset during DRIVE of slot 2.
        digits_in = 16'h1245;
        align(2 * CLK_DIV + 4);
        check("pre_reset_an", an_n, 4'b1011);
        check("pre_reset_dp", dp_n, 1'b0);
        #1 reset = 1'b1;
        #1;
        check("async_an", an_n, 4'hF);
        check("async_dp", dp_n, 1'b1);
        check_all();
        step(2);
        reset = 1'b0;
        #1;
        check("fs_after_rerelease", frame_start, 1);
        check_all();
        step(FRAME);

        // Randomized soak: inputs change at arbitrary cycles, including at frame start.
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            check_all();
            if ($urandom_range(0, 7) == 0) begin
                for (int j = 0; j < 4; j++) begin
                    digits_in[4*j +: 4] = 4'($urandom_range(0, 11));
                end
            end
            if ($urandom_range(0, 5) == 0) pm = 1'($urandom);
            if ($urandom_range(0, 5) == 0) colon_on = 1'($urandom);
            if ($urandom_range(0, 9) == 0) dim = 2'($urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
